// File: rtl/seg_display_reader.sv
// Receive side of a multiplexed active-low 7-segment bus: recovers BCD frames over valid/ready.
// Optional decimal-point capture enabled by defining SEGRX_DP_EN (adds dp_out).
module seg_display_reader #(
  parameter int DIGITS = 4,
  parameter int SETTLE = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            seg_n,
  input  logic [DIGITS-1:0]     dig_n,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  err_pulse,
`ifdef SEGRX_DP_EN
  output logic                  overrun,
  output logic [DIGITS-1:0]     dp_out
`else
  output logic                  overrun
`endif
);

`ifdef SEGRX_DP_EN
  localparam int SEGW = 8;
`else
  localparam int SEGW = 7;
`endif
  localparam int SW = DIGITS + SEGW;
  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SETTLE_C    = CW'(SETTLE);
  localparam logic [CW-1:0] SETTLE_M1_C = CW'(SETTLE - 1);

  logic [SEGW-1:0]     seg_s1_q, seg_s_q;
  logic [DIGITS-1:0]   dig_s1_q, dig_s_q;
  logic [SW-1:0]       samp, prev_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] work_q, work_d, bcd_q, bcd_d;
  logic [DIGITS-1:0]   seen_q, seen_d, set_mask;
  logic                fv_q, fv_d, err_q, err_d, ovr_q, ovr_d;
  logic                same, accept, complete, any_zero, multi_zero, hit;
  logic [3:0]          digit_val;
  logic [DIGITS-1:0]   dpw_q, dpw_d, dpo_q, dpo_d;

`ifndef SEGRX_DP_EN
  logic unused_dp;
  assign unused_dp = seg_n[7];
`endif

  function automatic logic [4:0] decode(input logic [6:0] code);
    case (code)
      7'h40: decode = {1'b1, 4'd0};
      7'h79: decode = {1'b1, 4'd1};
      7'h24: decode = {1'b1, 4'd2};
      7'h30: decode = {1'b1, 4'd3};
      7'h19: decode = {1'b1, 4'd4};
      7'h12: decode = {1'b1, 4'd5};
      7'h02: decode = {1'b1, 4'd6};
      7'h78: decode = {1'b1, 4'd7};
      7'h00: decode = {1'b1, 4'd8};
      7'h10: decode = {1'b1, 4'd9};
      default: decode = 5'd0;
    endcase
  endfunction

  assign samp = {dig_s_q, seg_s_q};

  // Stability counter: accept fires once, on the SETTLE-1 -> SETTLE step of a stable run
  always_comb begin
    same   = (samp == prev_q);
    accept = same && (cnt_q == SETTLE_M1_C);
    if (!same)
      cnt_d = CW'(1);
    else if (cnt_q < SETTLE_C)
      cnt_d = cnt_q + CW'(1);
    else
      cnt_d = cnt_q;
  end

  always_comb begin
    any_zero   = 1'b0;
    multi_zero = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!dig_s_q[i]) begin
        if (any_zero) multi_zero = 1'b1;
        any_zero = 1'b1;
      end
    end
    {hit, digit_val} = decode(seg_s_q[6:0]);
  end

  always_comb begin
    work_d   = work_q;
    dpw_d    = dpw_q;
    set_mask = '0;
    err_d    = 1'b0;
    complete = &seen_q;
    if (accept && any_zero) begin
      if (multi_zero || !hit) begin
        err_d = 1'b1;
      end else begin
        for (int i = 0; i < DIGITS; i++) begin
          if (!dig_s_q[i]) begin
            work_d[4*i +: 4] = digit_val;
            set_mask[i]      = 1'b1;
`ifdef SEGRX_DP_EN
            dpw_d[i]         = ~seg_s_q[7];
`endif
          end
        end
      end
    end
    seen_d = (complete ? '0 : seen_q) | set_mask;

    // A finished frame either replaces the delivered one or is dropped as an overrun
    bcd_d = bcd_q;
    dpo_d = dpo_q;
    fv_d  = fv_q;
    ovr_d = 1'b0;
    if (complete) begin
      if (!fv_q || frame_ready) begin
        bcd_d = work_q;
        dpo_d = dpw_q;
        fv_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (fv_q && frame_ready) begin
      fv_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q <= '0;
      seg_s_q  <= '0;
      dig_s1_q <= '0;
      dig_s_q  <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      work_q   <= '0;
      seen_q   <= '0;
      bcd_q    <= '0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
      ovr_q    <= 1'b0;
      dpw_q    <= '0;
      dpo_q    <= '0;
    end else begin
      seg_s1_q <= seg_n[SEGW-1:0];
      seg_s_q  <= seg_s1_q;
      dig_s1_q <= dig_n;
      dig_s_q  <= dig_s1_q;
      prev_q   <= samp;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      seen_q   <= seen_d;
      bcd_q    <= bcd_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
      ovr_q    <= ovr_d;
      dpw_q    <= dpw_d;
      dpo_q    <= dpo_d;
    end
  end

  assign bcd_out     = bcd_q;
  assign frame_valid = fv_q;
  assign err_pulse   = err_q;
  assign overrun     = ovr_q;
`ifdef SEGRX_DP_EN
  assign dp_out      = dpo_q;
`else
  logic unused_dpo;
  assign unused_dpo = ^{dpw_q, dpo_q, dpw_d, dpo_d};
`endif

endmodule
